// File: rtl/led_disp_pkg.sv
// led_disp_pkg: shared constants and state encoding
// for the multiplexed LED display controller.
package led_disp_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam int DEF_SLOT_CYC = 100000;
  localparam int DEF_GAP_CYC  = 1000;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/led_scan_ctrl_if.sv
// led_scan_ctrl_if: frame load valid/ready bundle
// between a frame source and the scan controller.
interface led_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);

  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]   load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dp,
    output load_ready
  );

endinterface

// File: rtl/led_slot_timer.sv
// led_slot_timer: per-digit slot counter with
// dark-gap and last-cycle strobes.
module led_slot_timer
  import led_disp_pkg::*;
#(
  parameter int SLOT_CYC = DEF_SLOT_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_gap_active,
  output logic o_slot_end
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] GAP  = CW'(GAP_CYC);

  logic [CW-1:0] r_slot_cnt;

  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_slot_cnt <= '0;
    end else if (r_slot_cnt == LAST) begin
      r_slot_cnt <= '0;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  assign o_gap_active = (r_slot_cnt < GAP);
  assign o_slot_end   = i_run && (r_slot_cnt == LAST);

endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: round-robin 7-seg digit scanner with tear-free
// frame loading. LED_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module led_scan_ctrl
  import led_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT_CYC   = DEF_SLOT_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  led_scan_ctrl_if.slave        load,
  output logic [3:0]            digit_code,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_frame;
  logic [NUM_DIGITS-1:0] r_frame_dp;
  logic [DW-1:0]         r_pend;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend_vld;
  logic                  r_ready;

  logic                  w_gap;
  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_xfer;
  logic                  w_frame_ld;
  logic [DW-1:0]         w_src_data;
  logic [NUM_DIGITS-1:0] w_src_dp;
  logic [3:0]            w_cur_code;
  logic [3:0]            w_disp_code;

  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [3:0]            w_code_nxt;
  logic                  w_dpn_nxt;

  led_slot_timer #(
    .SLOT_CYC (SLOT_CYC),
    .GAP_CYC  (GAP_CYC)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_run        (r_state == SCAN),
    .o_gap_active (w_gap),
    .o_slot_end   (w_slot_end)
  );

  assign w_frame_end = w_slot_end && (r_idx == LAST_IDX);
  assign w_xfer      = load.load_valid && r_ready;
  assign load.load_ready = r_ready;

  // From IDLE the first frame bypasses the pending buffer.
  assign w_src_data = (r_state == IDLE) ? load.load_data : r_pend;
  assign w_src_dp   = (r_state == IDLE) ? load.load_dp   : r_pend_dp;
  assign w_frame_ld = ((r_state == IDLE) && w_xfer) ||
                      (w_frame_end && r_pend_vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_xfer) w_state_nxt = SCAN;
      SCAN: w_state_nxt = SCAN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE)) begin
      r_idx <= '0;
    end else if (w_frame_end) begin
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame    <= {NUM_DIGITS{BLANK_CODE}};
      r_frame_dp <= '0;
      r_pend     <= {NUM_DIGITS{BLANK_CODE}};
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      if (w_frame_ld) begin
        r_frame    <= w_src_data;
        r_frame_dp <= w_src_dp;
      end
      if (r_state == SCAN) begin
        if (w_frame_end && r_pend_vld) begin
          r_pend_vld <= 1'b0;
          r_ready    <= 1'b1;
        end
        if (w_xfer) begin
          r_pend     <= load.load_data;
          r_pend_dp  <= load.load_dp;
          r_pend_vld <= 1'b1;
          r_ready    <= 1'b0;
        end
      end
    end
  end

  assign w_cur_code = r_frame[{r_idx, 2'b00} +: 4];

`ifdef LED_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] r_lz_mask;
  logic [NUM_DIGITS-1:0] w_lz_nxt;
  logic                  w_lz_run;

  // Mask travels with the frame it was computed from.
  always_comb begin
    w_lz_run = 1'b1;
    w_lz_nxt = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_lz_run = w_lz_run &&
                 (w_src_data[4*i +: 4] == 4'h0) &&
                 !w_src_dp[i];
      w_lz_nxt[i] = w_lz_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lz_mask <= '0;
    end else if (w_frame_ld) begin
      r_lz_mask <= w_lz_nxt;
    end
  end

  assign w_disp_code = r_lz_mask[r_idx] ? BLANK_CODE : w_cur_code;
`else
  assign w_disp_code = w_cur_code;
`endif

  always_comb begin
    w_an_nxt   = '1;
    w_code_nxt = BLANK_CODE;
    w_dpn_nxt  = 1'b1;
    if ((r_state == SCAN) && !w_gap) begin
      w_an_nxt[r_idx] = 1'b0;
      w_code_nxt      = w_disp_code;
      w_dpn_nxt       = ~r_frame_dp[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_n       <= '1;
      digit_code <= BLANK_CODE;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an_n       <= w_an_nxt;
      digit_code <= w_code_nxt;
      dp_n       <= w_dpn_nxt;
      frame_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: directed and random frame loads checked
// against a cycle-count based display model.
module tb_led_scan_ctrl;
  import led_disp_pkg::*;

  localparam int N    = 4;
  localparam int SLOT = 8;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_scan_ctrl_if #(.NUM_DIGITS(N)) u_if ();

  logic [3:0]   digit_code;
  logic         dp_n;
  logic [N-1:0] an_n;
  logic         frame_done;

  led_scan_ctrl #(
    .NUM_DIGITS (N),
    .SLOT_CYC   (SLOT),
    .GAP_CYC    (GAP)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .load       (u_if),
    .digit_code (digit_code),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h want %0h @%0t",
                 tag, obs, exp, $time);
    end
  endtask

  bit           m_scan;
  int           m_k;
  logic [15:0]  m_frame;
  logic [N-1:0] m_dp;
  bit           m_pv;
  logic [15:0]  m_pend;
  logic [N-1:0] m_pend_dp;
  bit           m_ready;
  logic [N-1:0] e_an;
  logic [3:0]   e_code;
  logic         e_dpn;
  logic         e_done;

  function automatic int m_slot();
    return (m_k / SLOT) % N;
  endfunction

  function automatic int m_pos();
    return m_k % SLOT;
  endfunction

  function automatic logic [3:0] shown(int s);
    logic [3:0] c;
    c = m_frame[4*s +: 4];
`ifdef LED_SCAN_LZ_BLANK_EN
    if (s > 0) begin
      bit z;
      z = 1'b1;
      for (int j = s; j < N; j++)
        if (m_frame[4*j +: 4] != 4'h0 || m_dp[j]) z = 1'b0;
      if (z) c = 4'hF;
    end
`endif
    return c;
  endfunction

  task automatic model_step();
    int  pos;
    int  slot;
    bit  xfer;
    if (rst) begin
      m_scan = 0; m_k = 0; m_pv = 0; m_ready = 1;
      m_frame = '1; m_dp = '0;
      m_pend = '1; m_pend_dp = '0;
      e_an = '1; e_code = 4'hF; e_dpn = 1; e_done = 0;
      return;
    end
    pos  = m_pos();
    slot = m_slot();
    e_an = '1; e_code = 4'hF; e_dpn = 1; e_done = 0;
    if (m_scan) begin
      if (pos >= GAP) begin
        e_an   = ~(N'(1) << slot);
        e_code = shown(slot);
        e_dpn  = ~m_dp[slot];
      end
      e_done = (pos == SLOT - 1) && (slot == N - 1);
    end
    xfer = u_if.load_valid && m_ready;
    if (!m_scan) begin
      if (xfer) begin
        m_frame = u_if.load_data;
        m_dp    = u_if.load_dp;
        m_scan  = 1;
        m_k     = 0;
      end
    end else begin
      if (e_done && m_pv) begin
        m_frame = m_pend;
        m_dp    = m_pend_dp;
        m_pv    = 0;
        m_ready = 1;
      end
      if (xfer) begin
        m_pend    = u_if.load_data;
        m_pend_dp = u_if.load_dp;
        m_pv      = 1;
        m_ready   = 0;
      end
      m_k++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("an_n", an_n, e_an);
    chk("digit_code", digit_code, e_code);
    chk("dp_n", dp_n, e_dpn);
    chk("frame_done", frame_done, e_done);
    chk("load_ready", u_if.load_ready, m_ready);
    chk("an_onehot", $countones(~an_n) <= 1, 1);
  endtask

  task automatic send(logic [15:0] d, logic [N-1:0] p);
    bit acc;
    int budget;
    u_if.load_valid = 1'b1;
    u_if.load_data  = d;
    u_if.load_dp    = p;
    budget = 200;
    acc = 0;
    while (!acc && budget > 0) begin
      acc = u_if.load_ready;
      tick();
      budget--;
    end
    if (!acc) chk("send_timeout", 0, 1);
    u_if.load_valid = 1'b0;
  endtask

  task automatic wait_slot(int s, int p);
    int budget;
    budget = 400;
    while (!(m_scan && m_slot() == s && m_pos() == p)
           && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) chk("wait_timeout", 0, 1);
  endtask

  function automatic logic [15:0] rnd_frame();
    logic [15:0] v;
    for (int i = 0; i < N; i++)
      v[4*i +: 4] = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
    return v;
  endfunction

  initial begin
    int t0;
    int budget;
    bit acc;
    u_if.load_valid = 1'b0;
    u_if.load_data  = '0;
    u_if.load_dp    = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_an", an_n, 4'hF);
    chk("rst_code", digit_code, 4'hF);
    chk("rst_ready", u_if.load_ready, 1);
    repeat (50) tick();
    chk("idle_an", an_n, 4'hF);

    send(16'h4321, 4'b0010);
    wait_slot(1, 4);
    chk("s1_an", an_n, 4'b1101);
    chk("s1_code", digit_code, 4'h2);
    chk("s1_dp", dp_n, 0);
    wait_slot(2, 1);
    chk("gap_an", an_n, 4'b1111);

    budget = 100;
    while (!frame_done && budget > 0) begin tick(); budget--; end
    t0 = m_k;
    tick();
    budget = 100;
    while (!frame_done && budget > 0) begin tick(); budget--; end
    chk("fd_period", m_k - t0, 32);

    wait_slot(1, 3);
    send(16'h9999, 4'b0000);
    chk("ready_drop", u_if.load_ready, 0);
    send(16'h1234, 4'b1000);
    repeat (80) tick();

    wait_slot(0, 6);
    send(16'h5678, 4'b0001);
    wait_slot(2, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_an", an_n, 4'hF);
    chk("mrst_code", digit_code, 4'hF);
    chk("mrst_dp", dp_n, 1);
    chk("mrst_ready", u_if.load_ready, 1);
    repeat (20) tick();
    chk("mrst_idle", an_n, 4'hF);

    send(16'h0050, 4'b0000);
    repeat (40) tick();
    send(16'h0000, 4'b0000);
    repeat (70) tick();
    send(16'h0300, 4'b0100);
    repeat (70) tick();

    for (int c = 0; c < 2500; c++) begin
      if ($urandom % 400 == 0) begin
        rst = 1'b1;
        u_if.load_valid = 1'b0;
      end else begin
        rst = 1'b0;
      end
      if (!rst && !u_if.load_valid && $urandom % 20 == 0) begin
        u_if.load_valid = 1'b1;
        u_if.load_data  = rnd_frame();
        u_if.load_dp    = ($urandom % 2) ? N'($urandom) : '0;
      end
      acc = u_if.load_valid && u_if.load_ready;
      tick();
      if (acc) u_if.load_valid = 1'b0;
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
